mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port synchronous word memory between three requesters: program loader (LD),
//  core data load/store (DA) and core instruction fetch (IF). Sits between rv32 core and unified memory;
//  owns boot sequencing (core held in stall until image loaded) and per-cycle fetch/data arbitration.
// PARAMETERS
//  ADDR_W    10  word-address width to memory
//  DATA_W    32  data width
//  MAX_WAIT  4   consecutive IF denials before IF is forced to win one grant (1..15)
// PORTS
//  clk         in   1       clock, all state on rising edge
//  reset       in   1       asynchronous, active-low reset
//  boot_done   in   1       loader finished; level, sampled in BOOT
//  ld_req/ld_we in  1/1     loader request / write enable
//  ld_addr     in   ADDR_W  loader address;  ld_wdata in DATA_W
//  ld_gnt      out  1       loader granted this cycle
//  da_req/da_we in  1/1     data request / write enable (store)
//  da_addr     in   ADDR_W  ;  da_wdata in DATA_W
//  da_gnt      out  1       ;  da_rvalid out 1  load data valid on rdata
//  if_req      in   1       ;  if_addr in ADDR_W ;  if_gnt out 1 ;  if_rvalid out 1
//  rdata       out  DATA_W  memory read data (shared by all readers)
//  stall       out  1       freeze core PC/pipeline this cycle
//  mem_en/mem_we out 1/1    ;  mem_addr out ADDR_W ;  mem_wdata out DATA_W ;  mem_rdata in DATA_W
// BEHAVIOUR
//  - FSM {BOOT, RUN}. Reset -> BOOT. BOOT->RUN on cycle boot_done=1 and no LD grant that cycle. RUN is terminal until reset.
//  - BOOT: only LD may be granted (ld_gnt=ld_req); da_gnt=if_gnt=0; stall=1.
//  - RUN: LD ignored (ld_gnt=0). Winner per cycle: if wait_cnt>=MAX_WAIT and if_req -> IF; else DA if da_req; else IF if if_req.
//  - Grant is combinational same cycle as req; requester holds req/addr/we/wdata stable until gnt.
//  - Memory signals driven combinationally from winner; mem_en=any grant; mem_we=winner's we (IF never writes).
//  - Read latency 1: read granted in cycle N -> *_rvalid=1 in N+1 with rdata=mem_rdata; one rvalid per read grant.
//    Writes produce no rvalid. Back-to-back grants every cycle allowed (fully pipelined).
//  - wait_cnt (4b): RUN, if_req & ~if_gnt -> +1 saturating at MAX_WAIT; cleared on if_gnt or ~if_req.
//  - stall = BOOT | (if_req & ~if_gnt) | (da_req & ~da_gnt).
//  - Simultaneous DA+IF with wait_cnt<MAX_WAIT: DA wins, IF waits. With wait_cnt==MAX_WAIT: IF wins, DA waits.
//  - Reset asserted mid-operation: state->BOOT, wait_cnt=0, pending rvalid flags dropped (no rvalid next cycle).
//  - Reset values: state=BOOT, wait_cnt=0, da_rvalid=0, if_rvalid=0; all gnt=0 while reset low; stall=1.
//  - Address/data are passed through unmodified; no width conversion.
// CONFIGURATION
//  ARB_PERF_CNT_EN defined: adds outputs perf_if_gnt, perf_da_gnt, perf_stall (32b each), reset to 0,
//   increment on if_gnt, da_gnt, stall&RUN respectively; wrap at 2^32. Counting only in RUN.
//  Undefined: those ports and counters absent; arbitration behaviour identical.
// STRUCTURE
//  Package mem_arb_pkg: state enum {ST_BOOT, ST_RUN}, requester index constants REQ_LD/REQ_DA/REQ_IF,
//   default widths.
//  One sub-module: mem_arb_perf (the three counters), instantiated only under ARB_PERF_CNT_EN.
// TESTING
//  1 reset low 3 cycles, ld_req writes 0xDEADBEEF@0x010 -> ld_gnt=1,mem_we=1,stall=1; da/if_gnt stay 0.
//  2 boot_done=1, no ld_req -> RUN next cycle; if_req@0x000 -> if_gnt same cycle, if_rvalid next with mem_rdata.
//  3 RUN, da_req read@0x010 & if_req together -> da_gnt, stall=1; next cycle da_rvalid, rdata=0xDEADBEEF, if_gnt.
//  4 da_req held 6 cycles with if_req, MAX_WAIT=4 -> if_gnt on 5th cycle, wait_cnt clears, DA resumes after.
//  5 read granted, reset pulsed low before next edge -> no rvalid, state BOOT, stall=1.
//  6 ARB_PERF_CNT_EN: 10 fetch grants + 3 stall cycles in RUN -> perf_if_gnt=10, perf_stall=3.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// Defines the boot/run state encoding, requester indices into the grant vector,
// and the default bus widths used by the interface and the top.
package mem_arb_pkg;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } arb_state_e;

    // Bit positions in the one-hot grant vector
    localparam int REQ_LD  = 0;
    localparam int REQ_DA  = 1;
    localparam int REQ_IF  = 2;
    localparam int NUM_REQ = 3;

    localparam int DEF_ADDR_W   = 10;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_MAX_WAIT = 4;

    // Fetch-starvation counter width; MAX_WAIT must fit (1..15)
    localparam int WAIT_W = 4;

    // Performance counter width
    localparam int PERF_W = 32;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester, core-control and memory-side signals for the arbiter.
// Ports: boot_done, ld_*/da_*/if_* request buses with grants and read-valids,
// shared rdata, stall, and the single-port memory bus mem_*.
// Modport slave is the arbiter view; modport master is the core/loader/memory view.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              boot_done;

    logic              ld_req;
    logic              ld_we;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_gnt;

    logic              da_req;
    logic              da_we;
    logic [ADDR_W-1:0] da_addr;
    logic [DATA_W-1:0] da_wdata;
    logic              da_gnt;
    logic              da_rvalid;

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;

    logic [DATA_W-1:0] rdata;
    logic              stall;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  boot_done,
        input  ld_req, ld_we, ld_addr, ld_wdata,
        output ld_gnt,
        input  da_req, da_we, da_addr, da_wdata,
        output da_gnt, da_rvalid,
        input  if_req, if_addr,
        output if_gnt, if_rvalid,
        output rdata, stall,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output boot_done,
        output ld_req, ld_we, ld_addr, ld_wdata,
        input  ld_gnt,
        output da_req, da_we, da_addr, da_wdata,
        input  da_gnt, da_rvalid,
        output if_req, if_addr,
        input  if_gnt, if_rvalid,
        input  rdata, stall,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_arb_perf.sv
// Purpose: event counters for fetch grants, data grants and run-time stall cycles.
// Latency: counts appear one cycle after the counted event.
// Backpressure: none; observes grant/stall levels only, never blocks.
// Ports: clk, reset (async active-low), count_en (arbiter in RUN), if_gnt, da_gnt,
// stall in; perf_if_gnt, perf_da_gnt, perf_stall out (wrap at 2^32).
module mem_arb_perf
    import mem_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              count_en,
    input  logic              if_gnt,
    input  logic              da_gnt,
    input  logic              stall,
    output logic [PERF_W-1:0] perf_if_gnt,
    output logic [PERF_W-1:0] perf_da_gnt,
    output logic [PERF_W-1:0] perf_stall
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_if_gnt <= '0;
            perf_da_gnt <= '0;
            perf_stall  <= '0;
        end else if (count_en) begin
            if (if_gnt) perf_if_gnt <= perf_if_gnt + PERF_W'(1);
            if (da_gnt) perf_da_gnt <= perf_da_gnt + PERF_W'(1);
            if (stall)  perf_stall  <= perf_stall + PERF_W'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-port sync memory between loader, core data and core fetch; owns boot stall.
// Latency: grant and memory request combinational in the request cycle; read data/rvalid one cycle later.
// Backpressure: losing requester sees no gnt and holds its request; core is stalled while any core request waits.
// Ports: clk, reset (async active-low), bus (mem_port_arbiter_if.slave).
// Optional macro ARB_PERF_CNT_EN adds perf_if_gnt / perf_da_gnt / perf_stall counter outputs.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int MAX_WAIT = DEF_MAX_WAIT
)(
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] perf_if_gnt,
    output logic [PERF_W-1:0] perf_da_gnt,
    output logic [PERF_W-1:0] perf_stall
`endif
);

    localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);

    arb_state_e         state;
    logic [WAIT_W-1:0]  wait_cnt;
    logic               da_rvalid_q;
    logic               if_rvalid_q;

    logic [NUM_REQ-1:0] gnt;
    logic               run;
    logic               if_force;
    logic               stall_c;

    logic               mux_we;
    logic [ADDR_W-1:0]  mux_addr;
    logic [DATA_W-1:0]  mux_wdata;

    assign run = (state == ST_RUN);

    // Fetch has been denied MAX_WAIT times in a row: it overrides data priority once.
    assign if_force = (wait_cnt >= MAX_WAIT_C) && bus.if_req;

    // Winner selection. Grants are gated by reset itself so nothing reaches
    // memory while reset is held, not just after the first clock edge.
    always_comb begin
        gnt = '0;
        if (reset) begin
            if (!run) begin
                gnt[REQ_LD] = bus.ld_req;
            end else if (if_force) begin
                gnt[REQ_IF] = 1'b1;
            end else if (bus.da_req) begin
                gnt[REQ_DA] = 1'b1;
            end else if (bus.if_req) begin
                gnt[REQ_IF] = 1'b1;
            end
        end
    end

    // Memory request mux driven straight from the winner.
    always_comb begin
        mux_we    = 1'b0;
        mux_addr  = '0;
        mux_wdata = '0;
        if (gnt[REQ_LD]) begin
            mux_we    = bus.ld_we;
            mux_addr  = bus.ld_addr;
            mux_wdata = bus.ld_wdata;
        end else if (gnt[REQ_DA]) begin
            mux_we    = bus.da_we;
            mux_addr  = bus.da_addr;
            mux_wdata = bus.da_wdata;
        end else if (gnt[REQ_IF]) begin
            mux_addr  = bus.if_addr;
        end
    end

    assign stall_c = !run
                   | (bus.if_req & ~gnt[REQ_IF])
                   | (bus.da_req & ~gnt[REQ_DA]);

    // Boot/run sequencing, fetch starvation counter and read-valid pipeline.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_BOOT;
            wait_cnt    <= '0;
            da_rvalid_q <= 1'b0;
            if_rvalid_q <= 1'b0;
        end else begin
            // Memory returns data one cycle after a granted read; stores produce nothing.
            da_rvalid_q <= gnt[REQ_DA] & ~bus.da_we;
            if_rvalid_q <= gnt[REQ_IF];

            case (state)
                ST_BOOT: begin
                    wait_cnt <= '0;
                    // A loader access in the same cycle defers the switch so it completes in BOOT.
                    if (bus.boot_done && !gnt[REQ_LD]) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.if_req && !gnt[REQ_IF]) begin
                        if (wait_cnt < MAX_WAIT_C) begin
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                default: begin
                    state    <= ST_BOOT;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.ld_gnt    = gnt[REQ_LD];
    assign bus.da_gnt    = gnt[REQ_DA];
    assign bus.if_gnt    = gnt[REQ_IF];
    assign bus.da_rvalid = da_rvalid_q;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.rdata     = bus.mem_rdata;
    assign bus.stall     = stall_c;

    assign bus.mem_en    = |gnt;
    assign bus.mem_we    = mux_we;
    assign bus.mem_addr  = mux_addr;
    assign bus.mem_wdata = mux_wdata;

`ifdef ARB_PERF_CNT_EN
    mem_arb_perf u_perf (
        .clk         (clk),
        .reset       (reset),
        .count_en    (run),
        .if_gnt      (gnt[REQ_IF]),
        .da_gnt      (gnt[REQ_DA]),
        .stall       (stall_c),
        .perf_if_gnt (perf_if_gnt),
        .perf_da_gnt (perf_da_gnt),
        .perf_stall  (perf_stall)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal checks plus a
// transaction-level model (boot flag, denial count, pending-read scoreboard,
// shadow memory) compared against the DUT on every falling clock edge.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int MW = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef ARB_PERF_CNT_EN
    logic [31:0] perf_if_gnt, perf_da_gnt, perf_stall;
`endif

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
`ifdef ARB_PERF_CNT_EN
        ,
        .perf_if_gnt (perf_if_gnt),
        .perf_da_gnt (perf_da_gnt),
        .perf_stall  (perf_stall)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int a);
        return 32'hA5A5_0000 | a;
    endfunction

    // Bench-side single-port memory with one-cycle read latency.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = init_word(i);
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            if (bus.mem_en === 1'b1) begin
                if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
                else            bus.mem_rdata <= mem[bus.mem_addr];
            end
        end
    end

    // ---------------- model state ----------------
    bit          m_run = 0;
    int          m_wait = 0;
    bit          m_pend_da = 0, m_pend_if = 0;
    logic [31:0] m_pend_data = '0;
    logic [31:0] m_mem [0:(1<<AW)-1];
    int          rst_epoch = 0;

    // Expectations computed at the falling edge, consumed at the rising edge.
    bit          e_ld, e_da, e_if, e_en, e_we, e_boot;
    logic [AW-1:0] e_addr;
    logic [31:0] e_wdata;
    int          e_wait_nxt;
    int          e_epoch = -1;

    initial begin : model
        for (int i = 0; i < (1 << AW); i++) m_mem[i] = init_word(i);
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_run = 0; m_wait = 0; m_pend_da = 0; m_pend_if = 0;
                rst_epoch++;
            end else if (e_epoch == rst_epoch) begin
                if (e_boot) m_run = 1;
                m_wait    = e_wait_nxt;
                m_pend_da = e_da && !e_we;
                m_pend_if = e_if;
                if (e_en && !e_we && (e_da || e_if)) m_pend_data = m_mem[e_addr];
                if (e_en && e_we) m_mem[e_addr] = e_wdata;
            end else begin
                // Reset pulsed since the last expectation: nothing was issued.
                m_pend_da = 0; m_pend_if = 0;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            e_epoch = rst_epoch;
            e_ld = 0; e_da = 0; e_if = 0;
            if (reset) begin
                if (!m_run) e_ld = bus.ld_req;
                else if (bus.if_req && (m_wait >= MW || !bus.da_req)) e_if = 1;
                else if (bus.da_req) e_da = 1;
            end
            e_en    = e_ld || e_da || e_if;
            e_we    = e_ld ? bus.ld_we : (e_da ? bus.da_we : 1'b0);
            e_addr  = e_ld ? bus.ld_addr : (e_da ? bus.da_addr : bus.if_addr);
            e_wdata = e_ld ? bus.ld_wdata : bus.da_wdata;
            e_boot  = reset && !m_run && bus.boot_done && !e_ld;
            if (m_run && bus.if_req && !e_if) e_wait_nxt = (m_wait + 1 > MW) ? MW : m_wait + 1;
            else                              e_wait_nxt = 0;

            chk("m_ld_gnt", bus.ld_gnt, e_ld);
            chk("m_da_gnt", bus.da_gnt, e_da);
            chk("m_if_gnt", bus.if_gnt, e_if);
            chk("m_stall",  bus.stall,
                !m_run || (bus.if_req && !e_if) || (bus.da_req && !e_da));
            chk("m_mem_en", bus.mem_en, e_en);
            if (e_en) begin
                chk("m_mem_we",   bus.mem_we,   e_we);
                chk("m_mem_addr", bus.mem_addr, e_addr);
                if (e_we) chk("m_mem_wdata", bus.mem_wdata, e_wdata);
            end
            chk("m_da_rvalid", bus.da_rvalid, m_pend_da);
            chk("m_if_rvalid", bus.if_rvalid, m_pend_if);
            if (m_pend_da || m_pend_if) chk("m_rdata", bus.rdata, m_pend_data);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin : stim
        int if_cyc;
        bus.boot_done = 0;
        bus.ld_req = 0; bus.ld_we = 0; bus.ld_addr = '0; bus.ld_wdata = '0;
        bus.da_req = 0; bus.da_we = 0; bus.da_addr = '0; bus.da_wdata = '0;
        bus.if_req = 0; bus.if_addr = '0;

        // Reset held three cycles
        reset = 0;
        @(negedge clk);
        chk("rst_stall", bus.stall, 1);
        chk("rst_ld_gnt", bus.ld_gnt, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1;

        // 1: loader write in BOOT; core requests ignored
        bus.ld_req = 1; bus.ld_we = 1; bus.ld_addr = 10'h010; bus.ld_wdata = 32'hDEADBEEF;
        bus.da_req = 1; bus.if_req = 1; bus.da_addr = 10'h001; bus.if_addr = 10'h002;
        @(negedge clk);
        chk("t1_ld_gnt", bus.ld_gnt, 1);
        chk("t1_mem_we", bus.mem_we, 1);
        chk("t1_mem_addr", bus.mem_addr, 32'h010);
        chk("t1_stall", bus.stall, 1);
        chk("t1_da_gnt", bus.da_gnt, 0);
        chk("t1_if_gnt", bus.if_gnt, 0);
        next_cycle();
        bus.ld_addr = 10'h011; bus.ld_wdata = 32'h12345678;
        next_cycle();
        bus.ld_req = 0; bus.da_req = 0; bus.if_req = 0;

        // 2: boot_done with no loader traffic, then first fetch
        bus.boot_done = 1;
        @(negedge clk);
        chk("t2_boot_stall", bus.stall, 1);
        next_cycle();
        bus.boot_done = 0;
        bus.if_req = 1; bus.if_addr = 10'h000;
        @(negedge clk);
        chk("t2_if_gnt", bus.if_gnt, 1);
        chk("t2_stall", bus.stall, 0);
        next_cycle();
        bus.if_req = 0;
        @(negedge clk);
        chk("t2_if_rvalid", bus.if_rvalid, 1);
        chk("t2_rdata", bus.rdata, 32'hA5A5_0000);

        // 3: data load and fetch collide; data wins first
        next_cycle();
        bus.da_req = 1; bus.da_we = 0; bus.da_addr = 10'h010;
        bus.if_req = 1; bus.if_addr = 10'h004;
        @(negedge clk);
        chk("t3_da_gnt", bus.da_gnt, 1);
        chk("t3_if_gnt0", bus.if_gnt, 0);
        chk("t3_stall", bus.stall, 1);
        next_cycle();
        bus.da_req = 0;
        @(negedge clk);
        chk("t3_da_rvalid", bus.da_rvalid, 1);
        chk("t3_rdata", bus.rdata, 32'hDEADBEEF);
        chk("t3_if_gnt", bus.if_gnt, 1);
        next_cycle();
        bus.if_req = 0;
        @(negedge clk);
        chk("t3_if_rdata", bus.rdata, 32'hA5A5_0004);

        // Store then load back the same word
        next_cycle();
        bus.da_req = 1; bus.da_we = 1; bus.da_addr = 10'h020; bus.da_wdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("st_mem_we", bus.mem_we, 1);
        next_cycle();
        bus.da_we = 0;
        @(negedge clk);
        chk("st_no_rvalid", bus.da_rvalid, 0);
        next_cycle();
        bus.da_req = 0;
        @(negedge clk);
        chk("ld_back_rdata", bus.rdata, 32'hCAFEF00D);

        // 4: continuous data traffic starves fetch until the 5th cycle
        if_cyc = 0;
        for (int c = 1; c <= 6; c++) begin
            next_cycle();
            bus.da_req = 1; bus.da_we = 0; bus.da_addr = AW'(10'h030 + c);
            bus.if_req = (if_cyc == 0); bus.if_addr = 10'h008;
            @(negedge clk);
            if (bus.if_gnt && if_cyc == 0) if_cyc = c;
            if (c == 5) chk("t4_da_wait", bus.da_gnt, 0);
            if (c == 6) chk("t4_da_resume", bus.da_gnt, 1);
        end
        chk("t4_if_gnt_cycle", if_cyc, 5);
        next_cycle();
        bus.da_req = 0; bus.if_req = 0;

        // 5: read granted, then reset pulsed before the next rising edge
        bus.da_req = 1; bus.da_addr = 10'h011;
        @(negedge clk);
        chk("t5_da_gnt", bus.da_gnt, 1);
        #2 reset = 0;
        #1 chk("t5_gnt_in_rst", bus.da_gnt, 0);
        #1 reset = 1;
        next_cycle();
        bus.da_req = 0; bus.if_req = 1; bus.if_addr = 10'h003;
        @(negedge clk);
        chk("t5_no_rvalid", bus.da_rvalid, 0);
        chk("t5_boot_if_gnt", bus.if_gnt, 0);
        chk("t5_stall", bus.stall, 1);
        next_cycle();
        bus.if_req = 0; bus.boot_done = 1;
        next_cycle();
        bus.boot_done = 0;

        // 6: ten fetch grants, then three stalled cycles
        for (int i = 0; i < 10; i++) begin
            bus.if_req = 1; bus.if_addr = AW'(i);
            next_cycle();
        end
        for (int k = 0; k < 3; k++) begin
            bus.da_req = 1; bus.da_we = 0; bus.da_addr = AW'(10'h040 + k);
            bus.if_req = 1; bus.if_addr = 10'h00A;
            next_cycle();
        end
        bus.da_req = 0; bus.if_req = 0;
        @(negedge clk);
`ifdef ARB_PERF_CNT_EN
        chk("t6_perf_if", perf_if_gnt, 10);
        chk("t6_perf_da", perf_da_gnt, 3);
        chk("t6_perf_stall", perf_stall, 3);
`endif
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #200000;
        fails++;
        $display("FAIL watchdog: got timeout, want completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
